// File: rtl/ad7960_pkg.sv
// Shared types and constants for the AD7960 ADC-side emulator.
package ad7960_pkg;

  localparam int ADC_W = 18;
  localparam int CNT_W = $clog2(ADC_W + 1);

  // One-hot FSM encoding; the spare code recovers to IDLE.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'b0001,
    ST_CONVERTING = 4'b0010,
    ST_SHIFTING   = 4'b0100,
    ST_SPARE      = 4'b1000
  } state_e;

  localparam logic [1:0] MODE_RAMP     = 2'd0;
  localparam logic [1:0] MODE_FIXED    = 2'd1;
  localparam logic [1:0] MODE_LFSR     = 2'd2;
  localparam logic [1:0] MODE_RAMP_ALT = 2'd3;

  // Fibonacci x^18 + x^11 + 1, shifting left.
  localparam int LFSR_TAP_HI = 17;
  localparam int LFSR_TAP_LO = 10;

  function automatic logic [ADC_W-1:0] lfsr_next(input logic [ADC_W-1:0] q);
    return {q[ADC_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/ad7960_pattern_gen.sv
// Conversion code source: ramp, fixed or LFSR. Registers step only when a
// conversion completes, and only the selected generator moves.
module ad7960_pattern_gen
  import ad7960_pkg::*;
#(
  parameter logic [ADC_W-1:0] RAMP_INIT  = 18'h00000,
  parameter logic [ADC_W-1:0] RAMP_STEP  = 18'h00001,
  parameter logic [ADC_W-1:0] FIXED_CODE = 18'h2AAAA,
  parameter logic [ADC_W-1:0] LFSR_SEED  = 18'h00001
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  input  logic [1:0]       mode_i,
  output logic [ADC_W-1:0] code_o
);

  logic [ADC_W-1:0] ramp_q, ramp_d;
  logic [ADC_W-1:0] lfsr_q, lfsr_d;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    code_o = ramp_q;
    ramp_d = ramp_q;
    lfsr_d = lfsr_q;
    case (mode_i)
      MODE_FIXED: code_o = FIXED_CODE;
      MODE_LFSR:  code_o = lfsr_q;
      default:    code_o = ramp_q;
    endcase
    if (advance_i) begin
      if (mode_i == MODE_LFSR) begin
        lfsr_d = lfsr_next(lfsr_q);
      end else if (mode_i != MODE_FIXED) begin
        ramp_d = ramp_q + RAMP_STEP;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ramp_q <= RAMP_INIT;
      lfsr_q <= LFSR_SEED;
    end else begin
      ramp_q <= ramp_d;
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/ad7960_adc_emulator.sv
// ADC-side responder for the AD7960 echoed-clock link: converts a generated code on
// each CNV rise and shifts it out MSB-first on cycles where the host gates its clock.
module ad7960_adc_emulator
  import ad7960_pkg::*;
#(
  parameter int unsigned      TCONV_CYC  = 4,
  parameter logic [ADC_W-1:0] RAMP_INIT  = 18'h00000,
  parameter logic [ADC_W-1:0] RAMP_STEP  = 18'h00001,
  parameter logic [ADC_W-1:0] FIXED_CODE = 18'h2AAAA,
  parameter logic [ADC_W-1:0] LFSR_SEED  = 18'h00001
) (
  input  logic             fast_clk_i,
  input  logic             buffer_reset_s,
  input  logic             cnv_i,
  input  logic             sclk_en_i,
  input  logic [1:0]       mode_i,
  output logic             d_o,
  output logic             dco_en_o,
  output logic [ADC_W-1:0] sample_o,
  output logic             conv_done_o,
  output logic             busy_o,
  output logic             collision_o,
  output logic             overrun_o
);

  localparam int TMR_W = (TCONV_CYC > 1) ? $clog2(TCONV_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TCONV_CYC - 1);
  localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(ADC_W);

  state_e           state_q, state_d;
  logic             cnv_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       mode_q, mode_d;
  logic [ADC_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             d_q, d_d;
  logic             dco_en_q, dco_en_d;
  logic [ADC_W-1:0] sample_q, sample_d;
  logic             done_q, done_d;
  logic             coll_q, coll_d;
  logic             over_q, over_d;
  logic [ADC_W-1:0] code;
  logic             rise;
  logic             load;

  assign rise = cnv_i & ~cnv_q;
  assign load = (state_q == ST_CONVERTING) && (timer_q == '0);

  ad7960_pattern_gen #(
    .RAMP_INIT (RAMP_INIT),
    .RAMP_STEP (RAMP_STEP),
    .FIXED_CODE(FIXED_CODE),
    .LFSR_SEED (LFSR_SEED)
  ) u_gen (
    .clk_i    (fast_clk_i),
    .rst_i    (buffer_reset_s),
    .advance_i(load),
    .mode_i   (mode_q),
    .code_o   (code)
  );

  // Shift engine runs in every state; a fresh result overrides any leftover bits.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    d_d       = d_q;
    dco_en_d  = 1'b0;
    sample_d  = sample_q;
    done_d    = 1'b0;
    coll_d    = 1'b0;
    over_d    = 1'b0;
    if (load) begin
      shift_d   = code;
      bit_cnt_d = BITS_FULL;
      sample_d  = code;
      done_d    = 1'b1;
      coll_d    = (bit_cnt_q != '0);
    end else if (sclk_en_i) begin
      if (bit_cnt_q != '0) begin
        d_d       = shift_q[ADC_W-1];
        shift_d   = shift_q << 1;
        dco_en_d  = 1'b1;
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
      end else begin
        over_d = 1'b1;
        d_d    = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE, ST_SHIFTING: begin
        if (rise) begin
          state_d = ST_CONVERTING;
          timer_d = TMR_LOAD;
          mode_d  = mode_i;
        end else if (state_q == ST_SHIFTING && bit_cnt_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_CONVERTING: begin
        if (load) state_d = ST_SHIFTING;
        else      timer_d = timer_q - TMR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fast_clk_i or posedge buffer_reset_s) begin
    if (buffer_reset_s) begin
      state_q   <= ST_IDLE;
      cnv_q     <= 1'b0;
      timer_q   <= '0;
      mode_q    <= MODE_RAMP;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      d_q       <= 1'b0;
      dco_en_q  <= 1'b0;
      sample_q  <= '0;
      done_q    <= 1'b0;
      coll_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnv_q     <= cnv_i;
      timer_q   <= timer_d;
      mode_q    <= mode_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      d_q       <= d_d;
      dco_en_q  <= dco_en_d;
      sample_q  <= sample_d;
      done_q    <= done_d;
      coll_q    <= coll_d;
      over_q    <= over_d;
    end
  end

  assign d_o         = d_q;
  assign dco_en_o    = dco_en_q;
  assign sample_o    = sample_q;
  assign conv_done_o = done_q;
  assign busy_o      = (state_q == ST_CONVERTING);
  assign collision_o = coll_q;
  assign overrun_o   = over_q;

endmodule
